ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Pipeline register between the execute stage (ALU) and the memory stage of the RISC-V core. Captures the ALU result, zero flag, store data and control bits, and resolves conditional branches from the zero flag. It provides a valid/ready handshake with a 2-entry skid buffer, so full throughput holds under downstream backpressure. It also issues a one-cycle redirect to fetch on a taken branch.

## Interface
- No parameters; data width fixed at 32, register index 5 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  execute stage presents a beat
- in_ready  output  1  combinational: `redirect_valid | ~skid_valid`
- alu_result  input  32  ALU output
- zero  input  1  ALU zero flag
- rs2_data  input  32  store data
- pc  input  32  instruction PC
- imm  input  32  sign-extended branch offset
- rd  input  5  destination register
- reg_write, mem_read, mem_write, mem_to_reg  input  1 each  control bits
- branch  input  1  conditional branch instruction
- branch_ne  input  1  1 = BNE, 0 = BEQ (meaningful only when branch=1)
- flush  input  1  synchronous kill from a later stage
- out_valid  output  1  memory-stage beat valid (= main_valid)
- out_ready  input  1  memory stage accepts
- out_alu_result, out_store_data  output  32 each  registered copies
- out_rd  output  5
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  output  1 each
- redirect_valid  output  1  one-cycle taken-branch pulse
- redirect_pc  output  32  branch target

## Operation
- Storage: main register (drives out_*) and skid register, each with a valid bit.
- pop = out_valid & out_ready.
- accept = in_valid & in_ready & ~redirect_valid & ~flush.
- A beat that handshakes while redirect_valid=1 or flush=1 is consumed and discarded. These are wrong-path or killed instructions.
- Update priority per cycle:
  - flush: main_valid=0, skid_valid=0.
  - else if pop or ~main_valid: main loads skid if skid_valid, else the input if accept, else goes empty; skid_valid=0.
  - else (main held): if accept, skid loads the input. This case occurs only when skid is empty.
- Taken branch: taken = branch & (branch_ne ? ~zero : zero), evaluated on accept.
  - redirect_valid next cycle = accept & taken & ~flush.
  - redirect_pc = pc + imm, mod 2^32 (wraps, no overflow detection); loaded whenever redirect_valid is set.
- Branch beats still propagate downstream with their control bits (reg_write=0 supplied by the decoder).
- out_* data fields hold their value when main is empty or stalled; only out_valid qualifies them.
- Ordering is strict FIFO: skid always drains into main before any newer beat.

## Timing
- Reset (rst_n=0 at a clock edge): main_valid=0, skid_valid=0, redirect_valid=0, redirect_pc=0, all out_* data/control = 0. in_ready=1 after reset.
- Latency: a beat accepted at edge t appears on out_* with out_valid=1 after edge t (1 cycle) when main is empty or popping.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure:
  - First stalled cycle: the beat is absorbed into skid.
  - in_ready falls to 0 the cycle after skid fills.
  - in_ready returns to 1 the cycle after the pop that drains skid.
- redirect_valid lasts exactly 1 cycle per taken branch. Back-to-back taken branches are impossible, because the beat after a redirect is always discarded.
- flush and redirect in the same cycle: flush wins for storage. The current redirect pulse still completes, since it belongs to an older instruction; no new redirect is generated.
- Reset asserted mid-stall or mid-redirect: all state clears at that edge; no partial beat emerges.
- in_valid must not depend combinationally on in_ready. out_ready may toggle freely.

## Test plan
- Streaming: 8 beats, alu_result=1..8, out_ready=1 → out_alu_result 1..8 in order, 1 cycle after each accept, no gaps; in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles while beats A=0x10, B=0x20, C=0x30 are presented:
  - main=A, skid=B, then in_ready=0 and C is held upstream.
  - after release: output A, B, C in order with no loss or duplication.
- BEQ taken: branch=1, branch_ne=0, zero=1, pc=0x100, imm=0x20 → next cycle redirect_valid=1, redirect_pc=0x120 for exactly 1 cycle. A beat presented in that cycle never reaches out_valid.
- BNE not taken / wrap: branch_ne=1, zero=1 → no redirect. BEQ taken with pc=0xFFFFFFF0, imm=0x20 → redirect_pc=0x00000010.
- Flush: with main and skid full, assert flush plus an input beat → next cycle out_valid=0, in_ready=1, and the flushed beats are never output.
- Reset mid-stall: rst_n=0 with skid full and redirect pending → next cycle all outputs 0, redirect_valid=0, in_ready=1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: valid/ready handshake with a 2-entry skid buffer,
// plus branch resolution from the ALU zero flag and a one-cycle fetch redirect.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic        zero,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_mem_to_reg,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } beat_t;

  beat_t       in_beat;
  beat_t       main_q, main_d;
  beat_t       skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        pop;
  logic        accept;
  logic        taken;

  // While a redirect is pending the incoming beat is wrong-path, so it is
  // always taken off the wire (ready) but never stored.
  assign in_ready = redirect_valid_q | ~skid_valid_q;
  assign pop      = main_valid_q & out_ready;
  assign accept   = in_valid & in_ready & ~redirect_valid_q & ~flush;
  assign taken    = branch & (branch_ne ? ~zero : zero);

  always_comb begin
    in_beat            = '0;
    in_beat.alu_result = alu_result;
    in_beat.store_data = rs2_data;
    in_beat.rd         = rd;
    in_beat.reg_write  = reg_write;
    in_beat.mem_read   = mem_read;
    in_beat.mem_write  = mem_write;
    in_beat.mem_to_reg = mem_to_reg;
  end

  // Skid always drains into main before a newer beat, which keeps strict
  // FIFO order; accept never coincides with a full skid (in_ready is low).
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop || !main_valid_q) begin
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
      end else if (accept) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    redirect_valid_d = accept & taken;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d) begin
      redirect_pc_d = pc + imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q           <= '0;
      skid_q           <= '0;
      main_valid_q     <= 1'b0;
      skid_valid_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      main_q           <= main_d;
      skid_q           <= skid_d;
      main_valid_q     <= main_valid_d;
      skid_valid_q     <= skid_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_alu_result = main_q.alu_result;
  assign out_store_data = main_q.store_data;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed beats push expectations,
// a monitor pops and compares every output handshake.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic        zero = 1'b0;
  logic [31:0] rs2_data = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic        branch = 1'b0;
  logic        branch_ne = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_mem_to_reg;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .zero(zero), .rs2_data(rs2_data), .pc(pc),
    .imm(imm), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
    .branch_ne(branch_ne), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_result(out_alu_result),
    .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        br;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Beat fields are derived from alu so the monitor can rebuild them.
  task automatic set_beat(input logic [31:0] alu, input logic br, input logic bne,
                          input logic z, input logic [31:0] pcv, input logic [31:0] immv);
    alu_result = alu;
    rs2_data   = ~alu;
    rd         = alu[4:0];
    reg_write  = ~br;
    mem_read   = alu[0];
    mem_write  = alu[1];
    mem_to_reg = alu[2];
    branch     = br;
    branch_ne  = bne;
    zero       = z;
    pc         = pcv;
    imm        = immv;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic drive(input logic [31:0] alu, input logic br, input logic bne,
                       input logic z, input logic [31:0] pcv, input logic [31:0] immv,
                       input bit keep, input bit timed, output int stalls);
    set_beat(alu, br, bne, z, pcv, immv);
    in_valid = 1'b1;
    stalls = 0;
    #1;
    while (!in_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: beat %h never accepted", alu);
    end else if (keep) begin
      sb.push_back('{alu: alu, br: br, exp_cyc: (timed ? cyc + 1 : -1)});
    end
    @(negedge clk);
    in_valid = 1'b0;
    branch   = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got alu %h, expected no beat", out_alu_result);
        end else begin
          e = sb.pop_front();
          check("out_alu_result", out_alu_result, e.alu);
          check("out_store_data", out_store_data, ~e.alu);
          check("out_rd", {27'd0, out_rd}, {27'd0, e.alu[4:0]});
          check("out_ctl", {28'd0, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg},
                {28'd0, ~e.br, e.alu[0], e.alu[1], e.alu[2]});
          if (e.exp_cyc >= 0) check("out_latency_cycle", 32'(cyc), 32'(e.exp_cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_out_alu_result", out_alu_result, 32'd0);
    check("rst_out_store_data", out_store_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // streaming
    for (int i = 1; i <= 8; i++) begin
      drive(32'(i), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, st);
      check("stream_no_stall", 32'(st), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("stream_drained", 32'(sb.size()), 32'd0);

    // backpressure: A to main, B to skid, C held upstream
    out_ready = 1'b0;
    drive(32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, st);
    drive(32'h20, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, st);
    check("bp_in_ready_skid_full", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_main_is_a", out_alu_result, 32'h10);
    set_beat(32'h30, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    check("bp_main_held_a", out_alu_result, 32'h10);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_in_ready_after_drain", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back('{alu: 32'h30, br: 1'b0, exp_cyc: -1});
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // branches
    drive(32'h55, 1'b1, 1'b0, 1'b1, 32'h100, 32'h20, 1'b1, 1'b1, st);
    check("beq_taken_redirect", {31'd0, redirect_valid}, 32'd1);
    check("beq_taken_pc", redirect_pc, 32'h120);
    check("redirect_in_ready", {31'd0, in_ready}, 32'd1);
    drive(32'h66, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, st);
    check("redirect_one_cycle", {31'd0, redirect_valid}, 32'd0);
    drive(32'h77, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, st);
    drive(32'h31, 1'b1, 1'b1, 1'b1, 32'h200, 32'h40, 1'b1, 1'b1, st);
    check("bne_not_taken", {31'd0, redirect_valid}, 32'd0);
    drive(32'h32, 1'b1, 1'b1, 1'b0, 32'h200, 32'hFFFF_FFF0, 1'b1, 1'b1, st);
    check("bne_taken_redirect", {31'd0, redirect_valid}, 32'd1);
    check("bne_taken_pc", redirect_pc, 32'h1F0);
    @(negedge clk);
    check("bne_redirect_ends", {31'd0, redirect_valid}, 32'd0);
    drive(32'h33, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, st);
    check("beq_wrap_redirect", {31'd0, redirect_valid}, 32'd1);
    check("beq_wrap_pc", redirect_pc, 32'h10);
    drive(32'h34, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, st);
    drive(32'h35, 1'b1, 1'b0, 1'b0, 32'h300, 32'h8, 1'b1, 1'b1, st);
    check("beq_not_taken", {31'd0, redirect_valid}, 32'd0);
    check("redirect_pc_held", redirect_pc, 32'h10);
    drive(32'h36, 1'b0, 1'b0, 1'b1, 32'h400, 32'h8, 1'b1, 1'b1, st);
    check("non_branch_zero", {31'd0, redirect_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("branch_drained", 32'(sb.size()), 32'd0);

    // flush with main and skid full plus an incoming beat
    out_ready = 1'b0;
    drive(32'hA0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, st);
    drive(32'hB0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, st);
    set_beat(32'hC0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    drive(32'hD0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, st);
    repeat (3) @(negedge clk);
    check("flush_drained", 32'(sb.size()), 32'd0);

    // reset with skid full and a redirect pending
    out_ready = 1'b0;
    drive(32'h11, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, st);
    drive(32'h22, 1'b1, 1'b0, 1'b1, 32'h40, 32'h4, 1'b0, 1'b0, st);
    check("pre_rst_redirect", {31'd0, redirect_valid}, 32'd1);
    check("pre_rst_redirect_pc", redirect_pc, 32'h44);
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("mid_rst_redirect_pc", redirect_pc, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_alu", out_alu_result, 32'd0);
    check("mid_rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("mid_rst_out_reg_write", {31'd0, out_reg_write}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive(32'h44, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, st);
    repeat (3) @(negedge clk);
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
